sampletest_elastic: RTL and testbench
=====================================

# sampletest_elastic

Parametrised successor to the raster sample-test stage. It takes one triangle and one sample location per accepted transfer and evaluates three edge equations in a configurable-width datapath. It applies optional backface culling and a top-left-style tie rule, then passes hit position, colour and facing through an elastic valid/ready pipeline of configurable depth. Saturating sample and hit counters sit alongside the pipeline. It sits between the sample iterator (R16) and the shader/z-buffer interface (R16+PIPE_DEPTH).

## Interface
- SIGFIG, 24, bits in colour/position words
- RADIX, 10, fraction bits (informational; no rescaling performed)
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, colour channels
- EDGE_BITS, 13, signed width used for edge arithmetic after the sample shift
- PIPE_DEPTH, 2, register stages from input to output; legal range 1–8
- DROP_MISS, 0, 1 = misses never occupy a pipeline slot
- CNT_W, 32, width of statistics counters
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- tri_R16S  in  3×AXIS×SIGFIG signed  vertices A,B,C
- color_R16U  in  COLORS×SIGFIG  triangle colour
- sample_R16S  in  2×SIGFIG signed  sample (x,y), unjittered
- valid_R16H  in  1  input transfer offered
- ready_R16H  out  1  input transfer accepted when valid&ready
- cull_en_R16H  in  1  1 = reject back-facing hits; sampled with the input transfer
- stat_clr_H  in  1  synchronous clear of both counters
- hit_RoutS  out  AXIS×SIGFIG signed  {sample x, sample y, A.z}
- color_RoutU  out  COLORS×SIGFIG  colour
- backface_RoutH  out  1  hit came from back-facing winding
- hit_valid_RoutH  out  1  sample is inside the triangle
- valid_RoutH  out  1  output slot occupied
- ready_RoutH  in  1  downstream accepts
- cnt_samp_U  out  CNT_W  accepted inputs
- cnt_hit_U  out  CNT_W  accepted inputs that hit

## Operation
- Shift: s_v = tri_v.xy − sample, full SIGFIG width. Truncate to the low EDGE_BITS as signed. Callers guarantee the values fit; out-of-range values wrap and this is defined behaviour.
- Edges: e0=A→B, e1=B→C, e2=C→A. d_k = x1·y2 − x2·y1. Products are 2·EDGE_BITS wide; d_k is 2·EDGE_BITS+1 wide, so no overflow is possible.
- Front hit: d0≤0 & d1<0 & d2≤0.
- Back hit: d0≥0 & d1>0 & d2≥0.
- hit = valid & (front | (back & ~cull_en)). backface = back & ~front & hit.
- A degenerate triangle (all d=0) is never a hit, because of the d1 strictness.
- Depth is A.z; colour passes through unchanged.
- When DROP_MISS=1, a miss is accepted (ready honoured) but is not loaded into stage 1.
- Counters:
  - Update on each input handshake. cnt_samp +1; cnt_hit +1 if hit.
  - Both saturate at all-ones.
  - stat_clr_H has priority over an increment in the same cycle.

## Timing
- Stage k (1..PIPE_DEPTH) holds {valid, hit, backface, hit position, colour}.
- Stage k loads when ~valid_k | ready_{k+1}, where ready_{PIPE_DEPTH+1} = ready_RoutH.
- ready_R16H = ~valid_1 | ready_2 (the stage 1 load condition). It is forced to 0 while rst=1.
- Latency with no stall: output appears exactly PIPE_DEPTH cycles after the input handshake.
- Throughput is 1 transfer per cycle.
- Under backpressure, stages fill from the output backward. No data is lost or duplicated, and order is preserved.
- Output data stays stable while valid_RoutH & ~ready_RoutH.
- Reset values:
  - all stage valid bits 0
  - all data registers 0
  - backface_RoutH, hit_valid_RoutH, valid_RoutH = 0
  - both counters 0
- Reset asserted mid-stream discards all in-flight entries; no output handshake occurs in that cycle.
- A simultaneous input accept and output drain on a full pipe keeps the pipe full and the throughput intact.

## Test plan
- Front hit: A=(0,0), B=(0,64), C=(64,0), sample (16,16), cull_en=1 → d=(−1024,−2048,−1024), hit_valid=1, backface=0, valid_RoutH exactly PIPE_DEPTH cycles later; cnt_samp=1, cnt_hit=1.
- Winding/cull: B and C swapped, same sample → cull_en=1 gives hit_valid=0; cull_en=0 gives hit_valid=1, backface=1.
- Tie rule: original triangle with sample (0,16) on edge AB → hit (d0=0). Sample (32,32) on edge BC → miss (d1=0). Degenerate A=B=C → miss.
- Backpressure: PIPE_DEPTH=2, stream 6 consecutive valid samples, hold ready_RoutH=0 for cycles 3–5 → ready_R16H drops once both stages are full; all 6 outputs arrive in order, each exactly once.
- DROP_MISS=1: alternate hit and miss over 8 inputs → 4 outputs, all with hit_valid=1; cnt_samp=8, cnt_hit=4.
- Counters: CNT_W=4, 20 accepted hits → both counters 15. Then stat_clr_H is pulsed in the same cycle as an accepted input → both counters 0. Reset asserted mid-stream → valid_RoutH=0 on the next edge.

Source files
------------

// File: rtl/sampletest_elastic.sv
// rtl/sampletest_elastic.sv - edge-equation sample test with elastic output pipeline and saturating counters
//
// Packing: tri_R16S holds vertex v (A=0,B=1,C=2), axis a (x=0,y=1,z=2) at
// bits [(v*AXIS+a)*SIGFIG +: SIGFIG]; sample_R16S holds x in the low word and y in the high word.
// hit_RoutS is {sample x, sample y, A.z} with x in the most significant word.
module sampletest_elastic #(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int EDGE_BITS  = 13,
    parameter int PIPE_DEPTH = 2,
    parameter int DROP_MISS  = 0,
    parameter int CNT_W      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [3*AXIS*SIGFIG-1:0] tri_R16S,
    input  logic [COLORS*SIGFIG-1:0]        color_R16U,
    input  logic signed [2*SIGFIG-1:0]      sample_R16S,
    input  logic                            valid_R16H,
    output logic                            ready_R16H,
    input  logic                            cull_en_R16H,
    input  logic                            stat_clr_H,
    output logic signed [AXIS*SIGFIG-1:0]   hit_RoutS,
    output logic [COLORS*SIGFIG-1:0]        color_RoutU,
    output logic                            backface_RoutH,
    output logic                            hit_valid_RoutH,
    output logic                            valid_RoutH,
    input  logic                            ready_RoutH,
    output logic [CNT_W-1:0]                cnt_samp_U,
    output logic [CNT_W-1:0]                cnt_hit_U
);
    localparam int PW = AXIS * SIGFIG;
    localparam int CW = COLORS * SIGFIG;
    localparam int EW = 2 * EDGE_BITS;

    logic signed [SIGFIG-1:0] smp_x;
    logic signed [SIGFIG-1:0] smp_y;
    logic signed [SIGFIG-1:0] a_z;
    logic signed [SIGFIG-1:0] dx [3];
    logic signed [SIGFIG-1:0] dy [3];
    logic signed [EW-1:0]     ex [3];
    logic signed [EW-1:0]     ey [3];
    logic signed [EW-1:0]     p_fwd [3];
    logic signed [EW-1:0]     p_rev [3];
    logic signed [EW:0]       d [3];
    logic [2:0]               d_neg;
    logic [2:0]               d_pos;
    logic                     front;
    logic                     back;
    logic                     hit;
    logic                     backface;
    logic                     in_fire;
    logic [PW-1:0]            hit_pos;

    logic                     st_v   [1:PIPE_DEPTH];
    logic                     st_hit [1:PIPE_DEPTH];
    logic                     st_bf  [1:PIPE_DEPTH];
    logic [PW-1:0]            st_pos [1:PIPE_DEPTH];
    logic [CW-1:0]            st_col [1:PIPE_DEPTH];
    logic [PIPE_DEPTH:1]      rdy;

    logic [CNT_W-1:0]         cnt_one;
    logic                     unused_bits;

    assign smp_x   = sample_R16S[SIGFIG-1:0];
    assign smp_y   = sample_R16S[2*SIGFIG-1:SIGFIG];
    assign a_z     = tri_R16S[2*SIGFIG +: SIGFIG];
    assign hit_pos = {smp_x, smp_y, a_z};
    assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Shift vertices to sample-relative coordinates, wrap to EDGE_BITS and evaluate the edge functions
    always_comb begin
        d_neg = '0;
        d_pos = '0;
        for (int v = 0; v < 3; v++) begin
            dx[v] = tri_R16S[(v*AXIS)*SIGFIG +: SIGFIG] - smp_x;
            dy[v] = tri_R16S[(v*AXIS+1)*SIGFIG +: SIGFIG] - smp_y;
            ex[v] = {{EDGE_BITS{dx[v][EDGE_BITS-1]}}, dx[v][EDGE_BITS-1:0]};
            ey[v] = {{EDGE_BITS{dy[v][EDGE_BITS-1]}}, dy[v][EDGE_BITS-1:0]};
        end
        for (int k = 0; k < 3; k++) begin
            p_fwd[k] = ex[k] * ey[(k+1)%3];
            p_rev[k] = ex[(k+1)%3] * ey[k];
            d[k]     = {p_fwd[k][EW-1], p_fwd[k]} - {p_rev[k][EW-1], p_rev[k]};
            d_neg[k] = d[k][EW];
            d_pos[k] = ~d[k][EW] & (d[k] != '0);
        end
    end

    // Middle edge is strict in both windings, so a degenerate triangle never hits
    assign front    = ~d_pos[0] & d_neg[1] & ~d_pos[2];
    assign back     = ~d_neg[0] & d_pos[1] & ~d_neg[2];
    assign hit      = valid_R16H & (front | (back & ~cull_en_R16H));
    assign backface = back & ~front & hit;

    // Stage k may load when it is empty or the stage after it is loading
    always_comb begin
        logic chain;
        rdy   = '0;
        chain = ready_RoutH;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            chain  = ~st_v[k] | chain;
            rdy[k] = chain;
        end
    end

    assign ready_R16H = rdy[1] & ~rst;
    assign in_fire    = valid_R16H & ready_R16H;

    // Elastic pipeline: stage 1 captures the test result, later stages shift forward when free
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                st_v[k]   <= 1'b0;
                st_hit[k] <= 1'b0;
                st_bf[k]  <= 1'b0;
                st_pos[k] <= '0;
                st_col[k] <= '0;
            end
        end else begin
            if (rdy[1]) begin
                st_v[1]   <= in_fire & ((DROP_MISS == 0) || hit);
                st_hit[1] <= hit;
                st_bf[1]  <= backface;
                st_pos[1] <= hit_pos;
                st_col[1] <= color_R16U;
            end
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                if (rdy[k]) begin
                    st_v[k]   <= st_v[k-1];
                    st_hit[k] <= st_hit[k-1];
                    st_bf[k]  <= st_bf[k-1];
                    st_pos[k] <= st_pos[k-1];
                    st_col[k] <= st_col[k-1];
                end
            end
        end
    end

    // Gating valid with reset keeps an in-flight entry from handshaking during the reset cycle
    assign valid_RoutH     = st_v[PIPE_DEPTH] & ~rst;
    assign hit_valid_RoutH = st_hit[PIPE_DEPTH];
    assign backface_RoutH  = st_bf[PIPE_DEPTH];
    assign hit_RoutS       = st_pos[PIPE_DEPTH];
    assign color_RoutU     = st_col[PIPE_DEPTH];

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || stat_clr_H) begin
            cnt_samp_U <= '0;
            cnt_hit_U  <= '0;
        end else if (in_fire) begin
            if (cnt_samp_U != '1) begin
                cnt_samp_U <= cnt_samp_U + cnt_one;
            end
            if (hit && (cnt_hit_U != '1)) begin
                cnt_hit_U <= cnt_hit_U + cnt_one;
            end
        end
    end

    // Wrapped-away high shift bits, B/C depth and the fixed-point position are intentionally ignored
    assign unused_bits = ^{tri_R16S, dx[0], dx[1], dx[2], dy[0], dy[1], dy[2], (RADIX != 0)};

endmodule

// File: tb/tb_sampletest_elastic.sv
// tb/tb_sampletest_elastic.sv - scoreboard bench for sampletest_elastic
module tb_sampletest_elastic;

    typedef struct {
        logic [71:0] pos;
        logic [71:0] col;
        logic        bf;
        logic        hv;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    exp_t qd[$];

    logic         clk = 1'b0;
    logic         rst;
    logic [215:0] tri_s;
    logic [71:0]  col;
    logic [47:0]  smp;
    logic         valid_m, valid_d, cull, clr, rout;

    logic         ready_m, bf_m, hv_m, vo_m;
    logic [71:0]  pos_m, col_m;
    logic [3:0]   cs_m, ch_m;
    logic         ready_d, bf_d, hv_d, vo_d;
    logic [71:0]  pos_d, col_d;
    logic [7:0]   cs_d, ch_d;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int nd_out = 0;
    exp_t e_m, e_d;

    logic [215:0] t1, t2, td;

    sampletest_elastic #(.PIPE_DEPTH(2), .DROP_MISS(0), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .tri_R16S(tri_s), .color_R16U(col), .sample_R16S(smp),
        .valid_R16H(valid_m), .ready_R16H(ready_m), .cull_en_R16H(cull), .stat_clr_H(clr),
        .hit_RoutS(pos_m), .color_RoutU(col_m), .backface_RoutH(bf_m), .hit_valid_RoutH(hv_m),
        .valid_RoutH(vo_m), .ready_RoutH(rout), .cnt_samp_U(cs_m), .cnt_hit_U(ch_m)
    );

    sampletest_elastic #(.PIPE_DEPTH(2), .DROP_MISS(1), .CNT_W(8)) dut_d (
        .clk(clk), .rst(rst), .tri_R16S(tri_s), .color_R16U(col), .sample_R16S(smp),
        .valid_R16H(valid_d), .ready_R16H(ready_d), .cull_en_R16H(cull), .stat_clr_H(clr),
        .hit_RoutS(pos_d), .color_RoutU(col_d), .backface_RoutH(bf_d), .hit_valid_RoutH(hv_d),
        .valid_RoutH(vo_d), .ready_RoutH(rout), .cnt_samp_U(cs_d), .cnt_hit_U(ch_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [215:0] mk_tri(input int ax, input int ay, input int az,
                                            input int bx, input int by, input int bz,
                                            input int cx, input int cy, input int cz);
        logic [215:0] t;
        t = {cz[23:0], cy[23:0], cx[23:0], bz[23:0], by[23:0], bx[23:0], az[23:0], ay[23:0], ax[23:0]};
        return t;
    endfunction

    function automatic logic [71:0] mk_col(input int i);
        return {24'(i + 1), 24'(i + 2), 24'(i + 3)};
    endfunction

    // Monitor: pop and compare whenever an output handshake is presented
    always @(negedge clk) begin
        if (vo_m && rout) begin
            if (q.size() == 0) begin
                chk("main_unexpected_output", 1, 0);
            end else begin
                e_m = q.pop_front();
                chk("main_pos", pos_m, e_m.pos);
                chk("main_color", col_m, e_m.col);
                chk("main_hit_valid", hv_m, e_m.hv);
                chk("main_backface", bf_m, e_m.bf);
                if (e_m.lat) chk("main_latency", cyc - e_m.cyc, 2);
            end
        end
        if (vo_d && rout) begin
            nd_out++;
            if (qd.size() == 0) begin
                chk("drop_unexpected_output", 1, 0);
            end else begin
                e_d = qd.pop_front();
                chk("drop_pos", pos_d, e_d.pos);
                chk("drop_color", col_d, e_d.col);
                chk("drop_hit_valid", hv_d, 1'b1);
                chk("drop_backface", bf_d, e_d.bf);
                if (e_d.lat) chk("drop_latency", cyc - e_d.cyc, 2);
            end
        end
    end

    task automatic send(input bit sel, input logic [215:0] t, input logic [71:0] c,
                        input int x, input int y, input int az, input bit cu, input bit cl,
                        input bit eh, input bit ebf, input bit lat);
        exp_t e;
        bit done;
        tri_s = t; col = c; smp = {y[23:0], x[23:0]}; cull = cu; clr = cl;
        if (sel) valid_d = 1'b1; else valid_m = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (sel ? ready_d : ready_m) begin
                e.pos = {x[23:0], y[23:0], az[23:0]};
                e.col = c; e.hv = eh; e.bf = ebf; e.cyc = cyc; e.lat = lat;
                if (!sel) q.push_back(e);
                else if (eh) qd.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("send_timeout", 1, 0);
        valid_m = 1'b0; valid_d = 1'b0; clr = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 50 && !empty; i++) begin
            @(negedge clk);
            empty = (q.size() == 0) && (qd.size() == 0);
        end
        if (!empty) chk("drain_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i;
        bit saw_low;
        t1 = mk_tri(0, 0, 5, 0, 64, 0, 64, 0, 0);
        t2 = mk_tri(0, 0, 5, 64, 0, 0, 0, 64, 0);
        td = mk_tri(10, 10, 5, 10, 10, 0, 10, 10, 0);
        rst = 1'b1; tri_s = '0; col = '0; smp = '0;
        valid_m = 1'b0; valid_d = 1'b0; cull = 1'b0; clr = 1'b0; rout = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid_out", vo_m, 0);
        chk("reset_ready_in", ready_m, 0);
        chk("reset_hit_valid", hv_m, 0);
        chk("reset_backface", bf_m, 0);
        chk("reset_cnt_samp", cs_m, 0);
        chk("reset_cnt_hit", ch_m, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // front hit, d = (-1024,-2048,-1024)
        send(0, t1, mk_col(0), 16, 16, 5, 1, 0, 1, 0, 1);
        drain();
        chk("front_cnt_samp", cs_m, 1);
        chk("front_cnt_hit", ch_m, 1);

        // swapped winding: culled, then accepted as back face
        send(0, t2, mk_col(1), 16, 16, 5, 1, 0, 0, 0, 1);
        send(0, t2, mk_col(2), 16, 16, 5, 0, 0, 1, 1, 1);
        // tie rule: on AB hits, on BC misses, degenerate misses
        send(0, t1, mk_col(3), 0, 16, 5, 1, 0, 1, 0, 1);
        send(0, t1, mk_col(4), 32, 32, 5, 1, 0, 0, 0, 1);
        send(0, td, mk_col(5), 16, 16, 5, 0, 0, 0, 0, 1);
        drain();
        chk("tie_cnt_samp", cs_m, 6);
        chk("tie_cnt_hit", ch_m, 3);

        // backpressure: ready_RoutH low for stream cycles 3..5
        i = 0; saw_low = 1'b0;
        for (int c = 0; c < 40 && i < 6; c++) begin
            exp_t e;
            rout = !(c >= 3 && c <= 5);
            tri_s = t1; col = mk_col(10 + i); smp = {24'd16, 24'd16}; cull = 1'b1; valid_m = 1'b1;
            @(negedge clk);
            if (!ready_m) saw_low = 1'b1;
            if (ready_m) begin
                e.pos = {24'd16, 24'd16, 24'd5}; e.col = mk_col(10 + i);
                e.hv = 1'b1; e.bf = 1'b0; e.cyc = cyc; e.lat = 1'b0;
                q.push_back(e);
                i++;
            end
            @(posedge clk); #1;
        end
        valid_m = 1'b0; rout = 1'b1;
        chk("bp_all_accepted", i, 6);
        chk("bp_ready_dropped", saw_low, 1);
        drain();
        chk("bp_cnt_samp", cs_m, 12);
        chk("bp_cnt_hit", ch_m, 9);

        // saturation at CNT_W=4
        for (int k = 0; k < 20; k++) send(0, t1, mk_col(k), 16, 16, 5, 1, 0, 1, 0, 1);
        drain();
        chk("sat_cnt_samp", cs_m, 15);
        chk("sat_cnt_hit", ch_m, 15);

        // clear in the same cycle as an accepted hit
        send(0, t1, mk_col(40), 16, 16, 5, 1, 1, 1, 0, 1);
        chk("clr_cnt_samp", cs_m, 0);
        chk("clr_cnt_hit", ch_m, 0);
        drain();

        // mid-stream reset discards held entries
        rout = 1'b0;
        send(0, t1, mk_col(50), 16, 16, 5, 1, 0, 1, 0, 0);
        send(0, t1, mk_col(51), 16, 16, 5, 1, 0, 1, 0, 0);
        @(negedge clk);
        chk("held_valid_out", vo_m, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_valid_out", vo_m, 0);
        chk("rst_cycle_ready_in", ready_m, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        rout = 1'b1;
        @(negedge clk);
        chk("post_rst_valid_out", vo_m, 0);
        chk("post_rst_cnt_samp", cs_m, 0);
        @(posedge clk); #1;
        send(0, t1, mk_col(60), 16, 16, 5, 1, 0, 1, 0, 1);
        drain();

        // DROP_MISS instance: alternating hit / miss
        nd_out = 0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) send(1, t1, mk_col(70 + k), 16, 16, 5, 1, 0, 1, 0, 1);
            else            send(1, t1, mk_col(70 + k), 32, 32, 5, 1, 0, 0, 0, 1);
        end
        drain();
        chk("drop_out_count", nd_out, 4);
        chk("drop_cnt_samp", cs_d, 8);
        chk("drop_cnt_hit", ch_d, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
